// File: rtl/alu_result_buffer_pkg.sv
// ---------------------------------------------------------------------------
// alu_result_buffer_pkg
//   Shared types for the ALU result buffer, alongside the ALU opcode package.
//   - Default field widths for the ROB tag, physical register index and data.
//   - alu_result_t: one completed ALU result as it travels to the CDB.
//   - fifo_op_e: per-cycle pointer operation seen by the FIFO controller.
// ---------------------------------------------------------------------------
package alu_result_buffer_pkg;

    localparam int ALU_DATA_WIDTH_DEF = 32;
    localparam int ROB_IDX_WIDTH_DEF  = 5;
    localparam int PREG_IDX_WIDTH_DEF = 6;
    localparam int RESULT_DEPTH_DEF   = 4;

    // Default-width result record. The buffer top uses the same field order,
    // sized from its own parameters, so a default build stores exactly this.
    typedef struct packed {
        logic [ROB_IDX_WIDTH_DEF-1:0]  rob_tag;
        logic [PREG_IDX_WIDTH_DEF-1:0] prd;
        logic                          rd_we;
        logic [ALU_DATA_WIDTH_DEF-1:0] data;
    } alu_result_t;

    // Encoding is {push, pop} so the operation can be formed by concatenation.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// ---------------------------------------------------------------------------
// alu_result_buffer_if
//   Bundle between the ALU / CDB arbiter side (master) and the result buffer
//   (slave).
//   master drives : flush, in_valid, in_rob_tag, in_prd, in_rd_we, in_data,
//                   cdb_grant
//   slave drives  : in_ready, cdb_valid, cdb_rob_tag, cdb_prd, cdb_rd_we,
//                   cdb_data, count
// ---------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_IDX_WIDTH  = 5,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int DEPTH          = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [ROB_IDX_WIDTH-1:0]  in_rob_tag;
    logic [PREG_IDX_WIDTH-1:0] in_prd;
    logic                      in_rd_we;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      cdb_valid;
    logic                      cdb_grant;
    logic [ROB_IDX_WIDTH-1:0]  cdb_rob_tag;
    logic [PREG_IDX_WIDTH-1:0] cdb_prd;
    logic                      cdb_rd_we;
    logic [DATA_WIDTH-1:0]     cdb_data;
    logic [CNT_W-1:0]          count;

    modport master (
        output flush, in_valid, in_rob_tag, in_prd, in_rd_we, in_data, cdb_grant,
        input  in_ready, cdb_valid, cdb_rob_tag, cdb_prd, cdb_rd_we, cdb_data, count
    );

    modport slave (
        input  flush, in_valid, in_rob_tag, in_prd, in_rd_we, in_data, cdb_grant,
        output in_ready, cdb_valid, cdb_rob_tag, cdb_prd, cdb_rd_we, cdb_data, count
    );

endinterface

// File: rtl/alu_result_buffer_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// result_fifo_ctrl
//   Pointer / occupancy bookkeeping for the ALU result buffer.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     i_push     : store one entry at o_wr_ptr this cycle
//     i_pop      : retire the entry at o_rd_ptr this cycle
//     i_flush    : discard everything; overrides push and pop
//     o_wr_ptr   : next write slot
//     o_rd_ptr   : head slot
//     o_count    : occupancy, 0..DEPTH
//     o_full     : o_count == DEPTH
//     o_empty    : o_count == 0
//   Callers must not push when full or pop when empty.
// ---------------------------------------------------------------------------
module result_fifo_ctrl
    import alu_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH)-1:0]   o_wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   o_rd_ptr,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    fifo_op_e         w_op;

    assign w_op = fifo_op(i_push, i_pop);

    // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (w_op)
                FIFO_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_count  <= r_count + CNT_W'(1);
                end
                FIFO_POP: begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_count  <= r_count - CNT_W'(1);
                end
                FIFO_BOTH: begin
                    // Occupancy unchanged, both pointers move.
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);

endmodule

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//   Result FIFO between the ALU and the CDB arbiter. Holds completed ALU
//   results until the arbiter grants a broadcast slot; backpressures issue
//   when full; flush discards all entries.
//   Ports:
//     clk     : system clock
//     rst     : asynchronous active-high reset
//     io_bus  : alu_result_buffer_if.slave (ALU input handshake, CDB output
//               handshake, flush, occupancy count)
//   Build option:
//     ALU_RESULT_BYPASS_EN : when defined, a result arriving at an empty
//     buffer is presented on the CDB in the same cycle; if granted it is
//     never written to storage.
// ---------------------------------------------------------------------------
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = ALU_DATA_WIDTH_DEF,
    parameter int ROB_IDX_WIDTH  = ROB_IDX_WIDTH_DEF,
    parameter int PREG_IDX_WIDTH = PREG_IDX_WIDTH_DEF,
    parameter int DEPTH          = RESULT_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_buffer_if.slave io_bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same layout as alu_result_t, sized from this instance's parameters.
    typedef struct packed {
        logic [ROB_IDX_WIDTH-1:0]  rob_tag;
        logic [PREG_IDX_WIDTH-1:0] prd;
        logic                      rd_we;
        logic [DATA_WIDTH-1:0]     data;
    } entry_t;

    entry_t           r_mem [DEPTH];

    entry_t           w_in_entry;
    entry_t           w_head_entry;
    entry_t           w_cdb_entry;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_stored_valid;
    logic             w_bypass;
    logic             w_bypass_take;
    logic             w_push;
    logic             w_pop;

    assign w_in_entry = '{
        rob_tag: io_bus.in_rob_tag,
        prd:     io_bus.in_prd,
        rd_we:   io_bus.in_rd_we,
        data:    io_bus.in_data
    };

    assign w_head_entry   = r_mem[w_rd_ptr];
    // Flush suppresses the head request in the flush cycle itself.
    assign w_stored_valid = !w_empty && !io_bus.flush;

`ifdef ALU_RESULT_BYPASS_EN
    assign w_bypass = w_empty && io_bus.in_valid && !io_bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed result that is granted in the same cycle never touches
    // storage; an ungranted one falls through to a normal push.
    assign w_bypass_take = w_bypass && io_bus.cdb_grant;

    // in_ready depends on registered occupancy only.
    assign io_bus.in_ready = !w_full;

    assign w_push = io_bus.in_valid && !w_full && !io_bus.flush && !w_bypass_take;
    assign w_pop  = w_stored_valid && io_bus.cdb_grant;

    assign io_bus.cdb_valid = w_stored_valid || w_bypass;

    // CDB fields are zero whenever nothing is being offered.
    always_comb begin
        w_cdb_entry = '0;
        if (w_bypass) begin
            w_cdb_entry = w_in_entry;
        end else if (w_stored_valid) begin
            w_cdb_entry = w_head_entry;
        end
    end

    assign io_bus.cdb_rob_tag = w_cdb_entry.rob_tag;
    assign io_bus.cdb_prd     = w_cdb_entry.prd;
    assign io_bus.cdb_rd_we   = w_cdb_entry.rd_we;
    assign io_bus.cdb_data    = w_cdb_entry.data;
    assign io_bus.count       = w_count;

    // Entry storage is deliberately not reset; only valid slots are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= w_in_entry;
        end
    end

    result_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_flush  (io_bus.flush),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

endmodule
